// File: rtl/pixel_packer.sv
// Packs 24-bit RGB / palette-index pixels into 32-bit words in the selected lcdbpp format.
// Define PIXEL_PACKER_BEPO_EN to honour big-endian pixel order (bepo); otherwise packing is always little-endian.
module pixel_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  lcdbpp,
    input  logic        bepo,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [23:0] pix_data,
    input  logic        flush,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [31:0] word_data,
    output logic        word_partial
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned OFS_W  = 5;
    localparam int unsigned WID_W  = 6;
    localparam int unsigned FMT_W  = 3;

    logic [WORD_W-1:0] acc;
    logic [OFS_W-1:0]  ofs;
    logic [FMT_W-1:0]  fmt_q;
    logic [FMT_W-1:0]  fmt;
    logic              eff_bepo;
    logic [WID_W-1:0]  w;
    logic [WID_W-1:0]  ofs_sum;
    logic [WID_W-1:0]  be_shift;
    logic [WORD_W-1:0] field;
    logic [WORD_W-1:0] placed;
    logic [WORD_W-1:0] acc_nxt;
    logic [WORD_W-1:0] word_in;
    logic              accept;
    logic              complete;
    logic              close;
    logic              load;

    assign pix_ready = ~rst & (~word_valid | word_ready);
    assign accept    = pix_valid & pix_ready;

    // Format is taken live for the first pixel of a word, then held from the latch.
    assign fmt = (ofs == '0) ? lcdbpp : fmt_q;

`ifdef PIXEL_PACKER_BEPO_EN
    logic bepo_q;
    assign eff_bepo = (ofs == '0) ? bepo : bepo_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            bepo_q <= 1'b0;
        end else if (accept && ofs == '0) begin
            bepo_q <= bepo;
        end
    end
`else
    logic unused_bepo;
    assign unused_bepo = bepo;
    assign eff_bepo    = 1'b0;
`endif

    // Pixel width and extracted field for the active format.
    always_comb begin
        w     = WID_W'(8);
        field = '0;
        case (fmt)
            3'd0: begin w = WID_W'(1);  field = WORD_W'(pix_data[0]);   end
            3'd1: begin w = WID_W'(2);  field = WORD_W'(pix_data[1:0]); end
            3'd2: begin w = WID_W'(4);  field = WORD_W'(pix_data[3:0]); end
            3'd3: begin w = WID_W'(8);  field = WORD_W'(pix_data[7:0]); end
            3'd4: begin
                w     = WID_W'(16);
                field = WORD_W'({pix_data[18], pix_data[23:19], pix_data[15:11], pix_data[7:3]});
            end
            3'd5: begin w = WID_W'(32); field = WORD_W'(pix_data);      end
            3'd6: begin
                w     = WID_W'(16);
                field = WORD_W'({pix_data[23:19], pix_data[15:10], pix_data[7:3]});
            end
            3'd7: begin
                w     = WID_W'(16);
                field = WORD_W'({pix_data[23:20], pix_data[15:12], pix_data[7:4]});
            end
            default: begin w = WID_W'(8); field = '0; end
        endcase
    end

    // Placement, completion and flush decisions.
    always_comb begin
        ofs_sum  = WID_W'(ofs) + w;
        be_shift = WID_W'(WORD_W) - ofs_sum;
        placed   = eff_bepo ? (field << be_shift) : (field << ofs);
        acc_nxt  = acc | placed;
        complete = accept & ofs_sum[WID_W-1];
        close    = pix_ready & flush & (pix_valid | (ofs != '0));
        load     = complete | close;
        word_in  = accept ? acc_nxt : acc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            ofs   <= '0;
            fmt_q <= '0;
        end else begin
            if (accept && ofs == '0) begin
                fmt_q <= lcdbpp;
            end
            if (load) begin
                acc <= '0;
                ofs <= '0;
            end else if (accept) begin
                acc <= acc_nxt;
                ofs <= ofs_sum[OFS_W-1:0];
            end
        end
    end

    // One-entry output register; a load can only occur when the slot is free or draining.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_valid   <= 1'b0;
            word_data    <= '0;
            word_partial <= 1'b0;
        end else if (load) begin
            word_valid   <= 1'b1;
            word_data    <= word_in;
            word_partial <= ~complete;
        end else if (word_ready) begin
            word_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pixel_packer.sv
// Self-checking bench for pixel_packer: directed literal cases plus random traffic vs a pixel-list model.
module tb_pixel_packer;

`ifdef PIXEL_PACKER_BEPO_EN
    localparam bit BEPO_EN = 1'b1;
`else
    localparam bit BEPO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  lcdbpp;
    logic        bepo;
    logic        pix_valid;
    logic        pix_ready;
    logic [23:0] pix_data;
    logic        flush;
    logic        word_valid;
    logic        word_ready;
    logic [31:0] word_data;
    logic        word_partial;

    int errors = 0;
    int checks = 0;

    pixel_packer dut (
        .clk(clk), .rst(rst), .lcdbpp(lcdbpp), .bepo(bepo),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .flush(flush), .word_valid(word_valid), .word_ready(word_ready),
        .word_data(word_data), .word_partial(word_partial)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: list of pending pixel fields, word built only when closed.
    logic [31:0] pix_list [32];
    int          npix = 0;
    logic [2:0]  m_fmt = '0;
    bit          m_be = 1'b0;
    bit          exp_valid = 1'b0;
    logic [31:0] exp_data = '0;
    bit          exp_partial = 1'b0;

    function automatic int width_of(input logic [2:0] f);
        case (f)
            3'd0: return 1;
            3'd1: return 2;
            3'd2: return 4;
            3'd3: return 8;
            3'd5: return 32;
            default: return 16;
        endcase
    endfunction

    function automatic logic [31:0] field_of(input logic [2:0] f, input logic [23:0] pd);
        case (f)
            3'd0: return {31'b0, pd[0]};
            3'd1: return {30'b0, pd[1:0]};
            3'd2: return {28'b0, pd[3:0]};
            3'd3: return {24'b0, pd[7:0]};
            3'd4: return {16'b0, pd[18], pd[23:19], pd[15:11], pd[7:3]};
            3'd5: return {8'h00, pd};
            3'd6: return {16'b0, pd[23:19], pd[15:10], pd[7:3]};
            default: return {20'b0, pd[23:20], pd[15:12], pd[7:4]};
        endcase
    endfunction

    task automatic emit(input bit partial);
        int wd;
        logic [31:0] word;
        wd = width_of(m_fmt);
        word = '0;
        for (int i = 0; i < npix; i++) begin
            if (m_be) word = word | (pix_list[i] << (32 - (i + 1) * wd));
            else      word = word | (pix_list[i] << (i * wd));
        end
        exp_valid   = 1'b1;
        exp_data    = word;
        exp_partial = partial;
        npix        = 0;
    endtask

    task automatic model_step();
        bit rdy;
        if (rst) begin
            exp_valid = 1'b0; exp_data = '0; exp_partial = 1'b0; npix = 0;
            return;
        end
        rdy = !exp_valid || word_ready;
        if (exp_valid && word_ready) exp_valid = 1'b0;
        if (!rdy) return;
        if (pix_valid) begin
            if (npix == 0) begin
                m_fmt = lcdbpp;
                m_be  = BEPO_EN ? bepo : 1'b0;
            end
            pix_list[npix] = field_of(m_fmt, pix_data);
            npix++;
            if (npix * width_of(m_fmt) == 32) emit(1'b0);
            else if (flush)                   emit(1'b1);
        end else if (flush && npix != 0) begin
            emit(1'b1);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Cycle-by-cycle comparison of DUT outputs against the model.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("pix_ready", 64'(pix_ready), 64'(!rst && (!exp_valid || word_ready)));
            chk("word_valid", 64'(word_valid), 64'(exp_valid));
            if (exp_valid) begin
                chk("word_data", 64'(word_data), 64'(exp_data));
                chk("word_partial", 64'(word_partial), 64'(exp_partial));
            end
        end
    end

    // Log of words transferred by the DUT, for the literal expectations.
    logic [32:0] dut_q [$];
    initial forever begin
        @(negedge clk);
        if (!rst && word_valid && word_ready) dut_q.push_back({word_partial, word_data});
    end

    task automatic xfer(input bit v, input logic [2:0] f, input logic be,
                        input logic [23:0] d, input logic fl);
        bit r;
        int n;
        lcdbpp = f; bepo = be; pix_data = d; pix_valid = v; flush = fl; n = 0;
        do begin
            @(negedge clk);
            r = pix_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!r && n < 100);
        if (!r) chk("handshake_timeout", 64'(0), 64'(1));
        pix_valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic idle(input int n);
        pix_valid = 1'b0;
        flush = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic expect_word(input string nm, input logic [32:0] exp);
        logic [32:0] got;
        got = (dut_q.size() != 0) ? dut_q.pop_front() : 33'h1_DEAD_BEEF;
        chk(nm, 64'(got), 64'(exp));
    endtask

    initial begin
        int nacc;
        logic [23:0] base;
        logic [23:0] nxt;
        bit r;

        rst = 1'b1; lcdbpp = '0; bepo = 1'b0; pix_valid = 1'b0; pix_data = '0;
        flush = 1'b0; word_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_word_valid", 64'(word_valid), 64'(0));
        chk("rst_word_data", 64'(word_data), 64'(0));
        chk("rst_word_partial", 64'(word_partial), 64'(0));
        chk("rst_pix_ready", 64'(pix_ready), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // 8 bpp little-endian
        dut_q.delete();
        xfer(1, 3'd3, 0, {16'($urandom), 8'h11}, 0);
        xfer(1, 3'd3, 0, {16'($urandom), 8'h22}, 0);
        xfer(1, 3'd3, 0, {16'($urandom), 8'h33}, 0);
        xfer(1, 3'd3, 0, {16'($urandom), 8'h44}, 0);
        idle(3);
        expect_word("bpp8_word", {1'b0, 32'h44332211});

        // 1 bpp alternating, big-endian when enabled
        for (int i = 0; i < 32; i++) xfer(1, 3'd0, 1, 24'((i % 2) == 0 ? 1 : 0), 0);
        idle(3);
        expect_word("bpp1_word", BEPO_EN ? {1'b0, 32'hAAAAAAAA} : {1'b0, 32'h55555555});

        // 5:6:5
        xfer(1, 3'd6, 0, 24'hF8FC00, 0);
        xfer(1, 3'd6, 0, 24'h0000F8, 0);
        idle(3);
        expect_word("rgb565_word", {1'b0, 32'h001FFFE0});

        // 4 bpp partial close, then a no-op flush
        xfer(1, 3'd2, 0, 24'h000001, 0);
        xfer(1, 3'd2, 0, 24'h000002, 0);
        xfer(1, 3'd2, 0, 24'h000003, 0);
        xfer(0, 3'd2, 0, 24'h000000, 1);
        idle(3);
        expect_word("flush_word", {1'b1, 32'h00000321});
        xfer(0, 3'd2, 0, 24'h000000, 1);
        idle(3);
        chk("noop_flush_count", 64'(dut_q.size()), 64'(0));

        // 24 bpp with a 5-cycle downstream stall
        dut_q.delete();
        base = 24'h10A000;
        nxt = base;
        nacc = 0;
        lcdbpp = 3'd5; bepo = 1'b0; pix_valid = 1'b1; flush = 1'b0; pix_data = nxt;
        for (int i = 0; i < 12; i++) begin
            word_ready = (i >= 5);
            @(negedge clk);
            r = pix_ready;
            if (i >= 1 && i < 5) chk("stall_pix_ready", 64'(r), 64'(0));
            @(posedge clk); #1;
            if (r) begin
                nacc++;
                nxt = nxt + 24'd1;
                pix_data = nxt;
            end
        end
        pix_valid = 1'b0;
        word_ready = 1'b1;
        idle(3);
        chk("stall_accepts", 64'(nacc), 64'(8));
        chk("stall_word_count", 64'(dut_q.size()), 64'(nacc));
        for (int k = 0; k < nacc; k++) expect_word("stall_order", {1'b0, 8'h00, base + 24'(k)});

        // reset mid-word discards the partial accumulation
        dut_q.delete();
        for (int i = 0; i < 5; i++) xfer(1, 3'd1, 0, 24'($urandom), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) xfer(1, 3'd1, 0, 24'h000003, 0);
        idle(3);
        expect_word("rst_first_word", {1'b0, 32'hFFFFFFFF});
        chk("rst_word_count", 64'(dut_q.size()), 64'(0));

        // random traffic checked cycle-by-cycle against the model
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 299) == 0);
            word_ready = ($urandom_range(0, 3) != 0);
            pix_valid  = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 15) == 0);
            pix_data   = 24'($urandom);
            bepo       = 1'($urandom);
            if ($urandom_range(0, 7) == 0) lcdbpp = 3'($urandom);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        word_ready = 1'b1;
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
